// File: rtl/ph_fifoquad_if.sv
// Parasite/host bus bundle for the parasite-to-host register quad.
//   master : parasite write side and host read side (drives strobes/data,
//            observes flags and read data)
//   slave  : the register quad itself
// Signals:
//   h_clr                    synchronous clear of all channels
//   p_we_b, p_selectData,
//   p_data                   parasite write strobe (active-low), channel
//                            select (bit i = R(i+1)), write byte
//   h_selectData, h_rdnw     host channel select and read strobe
//   one_byte_mode            R3 behaves as a 1-byte latch when high
//   h_data                   host read data (combinational)
//   h_data_available         per-channel readable flags
//   h_r3_two_bytes_available R3 holds two bytes
//   p_full                   per-channel full flags
interface ph_fifoquad_if;
  logic       h_clr;
  logic       p_we_b;
  logic [3:0] p_selectData;
  logic [7:0] p_data;
  logic [3:0] h_selectData;
  logic       h_rdnw;
  logic       one_byte_mode;
  logic [7:0] h_data;
  logic [3:0] h_data_available;
  logic       h_r3_two_bytes_available;
  logic [3:0] p_full;

  modport master (
    output h_clr, p_we_b, p_selectData, p_data, h_selectData, h_rdnw,
           one_byte_mode,
    input  h_data, h_data_available, h_r3_two_bytes_available, p_full
  );

  modport slave (
    input  h_clr, p_we_b, p_selectData, p_data, h_selectData, h_rdnw,
           one_byte_mode,
    output h_data, h_data_available, h_r3_two_bytes_available, p_full
  );
endinterface

// File: rtl/ph_fifoquad.sv
// Parasite-to-host register quad (single-clock Tube variant).
// R1 is an R1_DEPTH-byte circular FIFO, R3 a 2-byte FIFO with optional
// one-byte mode, R2/R4 single-byte latches with a valid bit.
// Ports:
//   h_phi2   clock, all state updates on the rising edge
//   h_rst_b  asynchronous active-low reset
//   bus      ph_fifoquad_if slave modport (strobes, data, flags)
module ph_fifoquad #(
  parameter int unsigned R1_DEPTH = 24
) (
  input  logic          h_phi2,
  input  logic          h_rst_b,
  ph_fifoquad_if.slave  bus
);

  localparam int unsigned PW = $clog2(R1_DEPTH);
  localparam int unsigned CW = $clog2(R1_DEPTH + 1);

  // R1 state
  logic [7:0]    mem1 [R1_DEPTH];
  logic [PW-1:0] wp1, rp1;
  logic [CW-1:0] cnt1;

  // R2/R4 latches
  logic [7:0] dat2, dat4;
  logic       val2, val4;

  // R3 state
  logic [7:0] mem3 [2];
  logic       wp3, rp3;
  logic [1:0] cnt3;

  logic [3:0] full, avail, wr, rd;

  // Pointers wrap modulo R1_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] inc1(input logic [PW-1:0] p);
    return (p == PW'(R1_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full[0]  = (cnt1 == CW'(R1_DEPTH));
    avail[0] = (cnt1 != '0);
    full[1]  = val2;
    avail[1] = val2;
    if (bus.one_byte_mode) begin
      full[2]  = (cnt3 != 2'd0);
      avail[2] = (cnt3 != 2'd0);
    end else begin
      full[2]  = (cnt3 == 2'd2);
      avail[2] = (cnt3 == 2'd2);
    end
    full[3]  = val4;
    avail[3] = val4;
  end

  // Flags are sampled before the edge, so a write to a full channel is
  // dropped even when the same edge pops that channel.
  assign wr = bus.p_selectData & {4{~bus.p_we_b}} & ~full & {4{~bus.h_clr}};
  assign rd = bus.h_selectData & {4{bus.h_rdnw}} & avail & {4{~bus.h_clr}};

  assign bus.p_full                   = full;
  assign bus.h_data_available         = avail;
  assign bus.h_r3_two_bytes_available = (cnt3 == 2'd2);

  // Storage carries no reset; only counts/pointers/valids define contents.
  always_ff @(posedge h_phi2) begin
    if (wr[0]) mem1[wp1] <= bus.p_data;
    if (wr[1]) dat2 <= bus.p_data;
    if (wr[2]) mem3[wp3] <= bus.p_data;
    if (wr[3]) dat4 <= bus.p_data;
  end

  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      wp1  <= '0;
      rp1  <= '0;
      cnt1 <= '0;
    end else if (bus.h_clr) begin
      wp1  <= '0;
      rp1  <= '0;
      cnt1 <= '0;
    end else begin
      if (wr[0]) wp1 <= inc1(wp1);
      if (rd[0]) rp1 <= inc1(rp1);
      if (wr[0] && !rd[0])      cnt1 <= cnt1 + 1'b1;
      else if (!wr[0] && rd[0]) cnt1 <= cnt1 - 1'b1;
    end
  end

  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      wp3  <= 1'b0;
      rp3  <= 1'b0;
      cnt3 <= 2'd0;
    end else if (bus.h_clr) begin
      wp3  <= 1'b0;
      rp3  <= 1'b0;
      cnt3 <= 2'd0;
    end else begin
      if (wr[2]) wp3 <= ~wp3;
      if (rd[2]) rp3 <= ~rp3;
      if (wr[2] && !rd[2])      cnt3 <= cnt3 + 2'd1;
      else if (!wr[2] && rd[2]) cnt3 <= cnt3 - 2'd1;
    end
  end

  // A latch can never write and pop on one edge: write needs !valid,
  // pop needs valid.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      val2 <= 1'b0;
      val4 <= 1'b0;
    end else if (bus.h_clr) begin
      val2 <= 1'b0;
      val4 <= 1'b0;
    end else begin
      if (wr[1])      val2 <= 1'b1;
      else if (rd[1]) val2 <= 1'b0;
      if (wr[3])      val4 <= 1'b1;
      else if (rd[3]) val4 <= 1'b0;
    end
  end

  // The highest-priority selected channel alone decides h_data; it does
  // not fall through to a lower channel when that one is empty.
  always_comb begin
    bus.h_data = '0;
    if (bus.h_selectData[0])      bus.h_data = avail[0] ? mem1[rp1] : '0;
    else if (bus.h_selectData[1]) bus.h_data = avail[1] ? dat2 : '0;
    else if (bus.h_selectData[2]) bus.h_data = avail[2] ? mem3[rp3] : '0;
    else if (bus.h_selectData[3]) bus.h_data = avail[3] ? dat4 : '0;
  end

endmodule

// File: tb/tb_ph_fifoquad.sv
module tb_ph_fifoquad;

  logic clk;
  logic rst_b;
  int   n_checks;
  int   n_fail;

  ph_fifoquad_if bus ();

  ph_fifoquad #(.R1_DEPTH(24)) dut (
    .h_phi2  (clk),
    .h_rst_b (rst_b),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.h_clr        = 1'b0;
    bus.p_we_b       = 1'b1;
    bus.p_selectData = 4'b0000;
    bus.p_data       = 8'h00;
    bus.h_selectData = 4'b0000;
    bus.h_rdnw       = 1'b0;
  endtask

  // Drive one cycle of stimulus, take the edge, sample 1 time unit later.
  task automatic step(input logic [3:0] psel, input logic we,
                      input logic [7:0] pd, input logic [3:0] hsel,
                      input logic rdnw, input logic clr);
    bus.p_selectData = psel;
    bus.p_we_b       = ~we;
    bus.p_data       = pd;
    bus.h_selectData = hsel;
    bus.h_rdnw       = rdnw;
    bus.h_clr        = clr;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [3:0] psel, input logic [7:0] pd);
    step(psel, 1'b1, pd, 4'b0000, 1'b0, 1'b0);
  endtask

  // Check the combinational head byte, then pop it on the edge.
  task automatic rd_check(input string tag, input logic [3:0] hsel,
                          input logic [7:0] exp);
    bus.h_selectData = hsel;
    bus.h_rdnw       = 1'b1;
    #1;
    check(tag, bus.h_data, exp);
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst_b             = 1'b0;
    bus.one_byte_mode = 1'b0;
    idle();
    #12;
    check("rst_full",  bus.p_full, 4'b0000);
    check("rst_avail", bus.h_data_available, 4'b0000);
    check("rst_two",   bus.h_r3_two_bytes_available, 1'b0);
    rst_b = 1'b1;

    // 1: R2 latch
    wr(4'b0010, 8'hA5);
    check("r2_full",  bus.p_full, 4'b0010);
    check("r2_avail", bus.h_data_available, 4'b0010);
    rd_check("r2_data", 4'b0010, 8'hA5);
    check("r2_full_clr",  bus.p_full, 4'b0000);
    check("r2_avail_clr", bus.h_data_available, 4'b0000);

    // 2: R1 fill, overflow drop, drain
    for (int i = 0; i < 24; i++) wr(4'b0001, 8'(i));
    check("r1_full", bus.p_full, 4'b0001);
    wr(4'b0001, 8'hFF);
    for (int i = 0; i < 24; i++) rd_check("r1_order", 4'b0001, 8'(i));
    check("r1_empty", bus.h_data_available, 4'b0000);
    check("r1_empty_data", bus.h_data, 8'h00);

    // 3: R1 pointer wrap (pointers start at 0 again after 24/24)
    for (int i = 0; i < 20; i++) wr(4'b0001, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) rd_check("r1_wrap_a", 4'b0001, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) wr(4'b0001, 8'(8'h80 + i));
    for (int i = 0; i < 10; i++) rd_check("r1_wrap_b", 4'b0001, 8'(8'h80 + i));
    check("r1_wrap_empty", bus.h_data_available, 4'b0000);

    // 4: R3 two-byte mode and mode switch
    wr(4'b0100, 8'h11);
    check("r3_avail_1", bus.h_data_available, 4'b0000);
    check("r3_full_1",  bus.p_full, 4'b0000);
    wr(4'b0100, 8'h22);
    check("r3_avail_2", bus.h_data_available, 4'b0100);
    check("r3_two_2",   bus.h_r3_two_bytes_available, 1'b1);
    check("r3_full_2",  bus.p_full, 4'b0100);
    rd_check("r3_first", 4'b0100, 8'h11);
    check("r3_avail_drop", bus.h_data_available, 4'b0000);
    check("r3_two_drop",   bus.h_r3_two_bytes_available, 1'b0);
    bus.one_byte_mode = 1'b1;
    #1;
    check("r3_obm_avail", bus.h_data_available, 4'b0100);
    check("r3_obm_full",  bus.p_full, 4'b0100);
    rd_check("r3_second", 4'b0100, 8'h22);
    check("r3_obm_empty", bus.h_data_available, 4'b0000);
    bus.one_byte_mode = 1'b0;

    // 5: concurrency on full R1 and on empty R4
    for (int i = 0; i < 24; i++) wr(4'b0001, 8'(8'hC0 + i));
    check("cc_full", bus.p_full, 4'b0001);
    bus.h_selectData = 4'b0001;
    #1;
    check("cc_head", bus.h_data, 8'hC0);
    step(4'b0001, 1'b1, 8'hEE, 4'b0001, 1'b1, 1'b0);
    check("cc_notfull", bus.p_full, 4'b0000);
    for (int i = 1; i < 24; i++) rd_check("cc_order", 4'b0001, 8'(8'hC0 + i));
    check("cc_dropped", bus.h_data_available, 4'b0000);
    step(4'b1000, 1'b1, 8'h5A, 4'b1000, 1'b1, 1'b0);
    check("r4_avail", bus.h_data_available, 4'b1000);
    rd_check("r4_data", 4'b1000, 8'h5A);
    check("r4_empty", bus.h_data_available, 4'b0000);

    // Priority: R2 selected with R1 empty yields 0, not R2's byte
    wr(4'b0010, 8'h3E);
    bus.h_selectData = 4'b0011;
    #1;
    check("prio_empty_r1", bus.h_data, 8'h00);
    idle();
    rd_check("prio_r2", 4'b0010, 8'h3E);

    // 6: clear beats same-edge write, then async reset mid-cycle
    for (int i = 0; i < 5; i++) wr(4'b0001, 8'(8'h10 + i));
    wr(4'b0100, 8'h99);
    check("pre_clr_avail", bus.h_data_available, 4'b0001);
    step(4'b0001, 1'b1, 8'h77, 4'b0000, 1'b0, 1'b1);
    check("clr_avail", bus.h_data_available, 4'b0000);
    check("clr_full",  bus.p_full, 4'b0000);
    check("clr_two",   bus.h_r3_two_bytes_available, 1'b0);
    wr(4'b0010, 8'h42);
    check("pre_rst_full", bus.p_full, 4'b0010);
    #2;
    rst_b = 1'b0;
    #1;
    check("arst_full",  bus.p_full, 4'b0000);
    check("arst_avail", bus.h_data_available, 4'b0000);
    #1;
    rst_b = 1'b1;
    wr(4'b0001, 8'h3C);
    rd_check("post_rst", 4'b0001, 8'h3C);
    check("post_rst_empty", bus.h_data_available, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
